poly1305_reduce_arbiter: RTL
============================

Name: poly1305_reduce_arbiter

Overview:
- Shares one Poly1305 modular-reduction unit (258-bit in, 130-bit out, start/done handshake) between NUM_REQ requesters, such as the MAC accumulator lanes.
- Arbitrates round-robin and sequences one start/done transaction at a time.
- Returns the tagged result to the winning requester over a valid/ready response channel.
- Guards against a hung reducer with a watchdog timeout.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IN_W, 258, reducer input width.
- OUT_W, 130, reducer output width.
- ID_W, 2, requester-ID width; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 64, maximum cycles in WAIT before abort (>=2).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request pending.
- req_data  in  NUM_REQ*IN_W  flattened operands; requester i occupies bits [i*IN_W +: IN_W].
- req_ready  out  NUM_REQ  one-hot grant/accept, combinational.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer accepts result.
- resp_id  out  ID_W  requester index of the result.
- resp_data  out  OUT_W  reduced value.
- resp_err  out  1  result aborted by timeout; resp_data is 0.
- red_start  out  1  start pulse to reducer.
- red_value_in  out  IN_W  operand to reducer.
- red_value_out  in  OUT_W  reducer result.
- red_done  in  1  reducer done pulse.
- red_busy  in  1  reducer busy; informational only.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; rr_ptr=0; timer=0.
  - resp_valid, resp_id, resp_data, resp_err, red_start, red_value_in, err_timeout all 0.
  - req_ready=0 while reset is asserted.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is one-hot on the granted i in this state only; all zero otherwise.
  - On that edge: latch req_data slice into red_value_in; latch i into resp_id; set rr_ptr=(i+1) mod NUM_REQ; go to ISSUE.
  - No req_valid: stay in IDLE, rr_ptr unchanged.
- ISSUE:
  - red_start=1 for exactly this one cycle; timer cleared.
  - Go to WAIT.
- WAIT:
  - red_start=0; timer increments each cycle.
  - red_done=1: capture red_value_out into resp_data; resp_err=0; go to RESP.
  - red_done=1 on the same cycle timer reaches TIMEOUT-1: done wins, no error.
  - Else if timer==TIMEOUT-1: resp_data=0; resp_err=1; err_timeout pulses 1 cycle; go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_data and resp_err held stable until resp_ready=1.
  - On the resp_valid&resp_ready edge: resp_valid=0; go to IDLE.
  - Next grant occurs in the following IDLE cycle, so the minimum gap between grants is 4 cycles.
- Stray red_done outside WAIT is ignored.
- req_valid deassert after grant has no effect, since the operand is already latched.
- Requester must hold req_data stable while req_valid=1 until granted.
- Latency:
  - Grant edge at cycle 0; red_start high in cycle 1.
  - With a reducer that asserts done one cycle after start: done in cycle 2, resp_valid from cycle 3.
- Reset mid-operation: all state discarded; no response is emitted for the in-flight request.
- Exactly one transaction in flight at any time; red_start is never reasserted before RESP completes.

Test Plan:
- Single request: requester 2 valid with data 258'h3_0000...0005, reducer model returns low 130 bits with done 1 cycle after start.
  -> req_ready=4'b0100 at cycle 0, red_start cycle 1, resp_valid cycle 3, resp_id=2, resp_data=130'h...0005, resp_err=0.
- Round robin: all 4 req_valid held high, resp_ready=1.
  -> grant order 0,1,2,3,0; each grant exactly 4 cycles apart; red_start never high twice within one transaction.
- Backpressure: resp_ready=0 for 10 cycles after resp_valid.
  -> resp_valid, resp_id and resp_data stable throughout; no new req_ready until 1 cycle after resp_ready=1.
- Timeout: reducer never asserts done, TIMEOUT=64.
  -> err_timeout 1-cycle pulse 64 cycles after red_start cycle; resp_err=1, resp_data=0; arbiter then serves the next requester normally.
- Done on timeout boundary: red_done asserted in the last WAIT cycle.
  -> resp_err=0, err_timeout stays 0, resp_data equals red_value_out.
- Reset mid-WAIT: deassert reset_n for 1 cycle while in WAIT.
  -> all outputs 0 immediately; late red_done ignored; next request is granted from requester 0.

Source files
------------

// File: rtl/poly1305_reduce_arbiter.sv
// Round-robin arbiter sharing one Poly1305 reduction unit among NUM_REQ requesters.
// One start/done transaction at a time, tagged valid/ready response, watchdog abort on a hung reducer.
module poly1305_reduce_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IN_W    = 258,
   parameter int OUT_W   = 130,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   input  logic [NUM_REQ*IN_W-1:0] req_data,
   output logic [NUM_REQ-1:0]      req_ready,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [ID_W-1:0]         resp_id,
   output logic [OUT_W-1:0]        resp_data,
   output logic                    resp_err,
   output logic                    red_start,
   output logic [IN_W-1:0]         red_value_in,
   input  logic [OUT_W-1:0]        red_value_out,
   input  logic                    red_done,
   input  logic                    red_busy,
   output logic                    err_timeout,
   output logic [1:0]              dbg_state
);

   // Handshakes: a request is accepted on any edge where req_valid[i] & req_ready[i];
   // a response is consumed on any edge where resp_valid & resp_ready.
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             r_state;
   logic [ID_W-1:0]    r_rr_ptr;
   logic [TW-1:0]      r_timer;
   logic               r_resp_valid;
   logic [ID_W-1:0]    r_resp_id;
   logic [OUT_W-1:0]   r_resp_data;
   logic               r_resp_err;
   logic               r_red_start;
   logic [IN_W-1:0]    r_red_value_in;
   logic               r_err_timeout;

   logic               w_grant_found;
   logic [ID_W-1:0]    w_grant_idx;
   logic [IN_W-1:0]    w_grant_data;
   logic [NUM_REQ-1:0] w_req_ready;
   logic               w_unused;

   // rr_ptr and grant indices are always below NUM_REQ, so one wrap suffices.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return ID_W'(s);
   endfunction

   always_comb begin
      w_grant_found = 1'b0;
      w_grant_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_grant_found && req_valid[wrap_add(r_rr_ptr, k)]) begin
            w_grant_found = 1'b1;
            w_grant_idx   = wrap_add(r_rr_ptr, k);
         end
      end
   end

   assign w_grant_data = req_data[w_grant_idx*IN_W +: IN_W];

   always_comb begin
      w_req_ready = '0;
      if (reset_n && (r_state == S_IDLE) && w_grant_found)
         w_req_ready[w_grant_idx] = 1'b1;
   end

   // r_timer counts cycles since the red_start cycle; the last WAIT cycle is TIMEOUT-1.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_rr_ptr       <= '0;
         r_timer        <= '0;
         r_resp_valid   <= 1'b0;
         r_resp_id      <= '0;
         r_resp_data    <= '0;
         r_resp_err     <= 1'b0;
         r_red_start    <= 1'b0;
         r_red_value_in <= '0;
         r_err_timeout  <= 1'b0;
      end else begin
         r_red_start   <= 1'b0;
         r_err_timeout <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_grant_found) begin
                  r_red_value_in <= w_grant_data;
                  r_resp_id      <= w_grant_idx;
                  r_rr_ptr       <= wrap_add(w_grant_idx, 1);
                  r_timer        <= '0;
                  r_red_start    <= 1'b1;
                  r_state        <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               r_timer <= r_timer + 1'b1;
               r_state <= S_WAIT;
            end
            S_WAIT: begin
               if (red_done) begin
                  r_resp_data  <= red_value_out;
                  r_resp_err   <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_state      <= S_RESP;
               end else if (r_timer == TW'(TIMEOUT - 1)) begin
                  r_resp_data   <= '0;
                  r_resp_err    <= 1'b1;
                  r_err_timeout <= 1'b1;
                  r_resp_valid  <= 1'b1;
                  r_state       <= S_RESP;
               end else begin
                  r_timer <= r_timer + 1'b1;
               end
            end
            S_RESP: begin
               if (resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign w_unused     = red_busy;
   assign req_ready    = w_req_ready;
   assign resp_valid   = r_resp_valid;
   assign resp_id      = r_resp_id;
   assign resp_data    = r_resp_data;
   assign resp_err     = r_resp_err;
   assign red_start    = r_red_start;
   assign red_value_in = r_red_value_in;
   assign err_timeout  = r_err_timeout;
   assign dbg_state    = r_state;

endmodule
